uart_port: RTL and testbench
============================

# uart_port

Board-side model of the external UART chip that the CPU drives through `rdn`/`wrn`/`data_ready`/`tbre`/`tsre`. It is the responder end of the CPU's UART handshake: it accepts byte writes and serialises them on `txd`, and it deserialises `rxd` into a holding register the CPU reads back. Byte traffic uses the low byte of the shared RAM1 data bus. The block is used in the FPGA-only build and as the UART counterpart in the system testbench.

## Interface
- `CLKS_PER_BIT`, default 96: clock cycles per serial bit (11.0592 MHz / 115200 baud).
- `clk`  in  1  block clock (clk_11MHz domain).
- `rst`  in  1  asynchronous, active-low reset.
- `data`  inout  8  low byte of the RAM1 data bus. Driven only while `rdn`=0; hi-Z otherwise.
- `rdn`  in  1  active-low read strobe from the CPU. Asynchronous to `clk`.
- `wrn`  in  1  active-low write strobe from the CPU. Asynchronous to `clk`.
- `data_ready`  out  1  the RX holding register contains an unread byte.
- `tbre`  out  1  TX buffer register empty.
- `tsre`  out  1  TX shift register empty; the line is idle.
- `rxd`  in  1  serial input, idles high.
- `txd`  out  1  serial output, idles high.

## Operation
- Reset values: `txd`=1, `tbre`=1, `tsre`=1, `data_ready`=0, `data` hi-Z. All FSMs return to IDLE and the RX holding register is cleared to 0x00. Reset asserted mid-frame aborts the frame immediately.
- `rdn`, `wrn` and `rxd` each pass through a 2-flop synchroniser. Edges are detected on the synchronised signals.
- **Read path**
  - `data` = RX holding register, driven combinationally while raw `rdn`=0.
  - `data_ready` clears on the synchronised `rdn` rising edge.
- **Write path**
  - On the first cycle the synchronised `wrn` is seen low, the block latches `data` into the TX holding register and drives `tbre`=0.
  - A write while `tbre`=0 is ignored. The holding register is unchanged.
- **TX FSM: IDLE → START → DATA → STOP → IDLE**
  - In IDLE with the holding register full: copy it into the shifter, set `tbre`=1 and `tsre`=0, and go to START.
  - START sends `txd`=0. DATA sends 8 bits, LSB first. STOP sends `txd`=1.
  - Each state or bit lasts exactly `CLKS_PER_BIT` cycles.
  - On leaving STOP: if the holding register is full, go straight back to START (back-to-back frames with no idle gap). Otherwise `tsre`=1.
- **RX FSM: IDLE → START → DATA → STOP → IDLE**
  - A falling edge of the synchronised `rxd` in IDLE enters START.
  - At `CLKS_PER_BIT/2`, if `rxd` is high again the block treats it as a glitch and returns to IDLE.
  - Each of the 8 data bits is sampled at its mid-point, LSB first.
  - The stop bit is sampled at its mid-point:
    - 1: load the holding register and set `data_ready`=1.
    - 0 (framing error): discard the byte; `data_ready` is unchanged.
- Overrun: a new valid byte overwrites the holding register and `data_ready` stays 1.
- Simultaneous load and read-clear in the same cycle: the load wins and `data_ready`=1.
- Bit counter is 3 bits and wraps 7→0 on the DATA→STOP transition. The baud counter width is `$clog2(CLKS_PER_BIT)`.

## Timing
- CPU obligations:
  - Hold `data` valid for the whole `wrn` low period.
  - Keep `wrn` and `rdn` low for at least 3 `clk` cycles.
  - Keep them high for at least 3 cycles between strobes.
- `tbre` falls 3 cycles after the `wrn` falling edge (2 sync + 1 latch).
- `txd` start bit begins no more than 5 cycles after the `wrn` falling edge. `tbre` returns to 1 on that same cycle.
- A frame takes `10*CLKS_PER_BIT` cycles. `tsre` rises the cycle after the stop bit ends.
- `data_ready` rises 1 cycle after the stop-bit sample, i.e. about `9.5*CLKS_PER_BIT` + 3 cycles after the `rxd` falling edge.
- `data_ready` falls 3 cycles after the `rdn` rising edge.

## Structure
- Add to `define.v`:
  - `UART_DATA_BUS` (7:0).
  - The shared 2-bit FSM encodings `UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`.
- Sub-module `uart_rx`: synchroniser, RX FSM and holding register; outputs byte plus valid strobe.
- TX FSM, strobe synchronisers and bus drive stay in `uart_port`.

## Test plan
- Reset with `rxd`=1 → `txd`=1, `tbre`=1, `tsre`=1, `data_ready`=0, `data` hi-Z. Pulse reset low mid-TX-frame → same values next cycle.
- Write 0xA5 → `txd` bits 0,1,0,1,0,0,1,0,1,1, each 96 cycles. `tbre` low for 2–3 cycles, then 1. `tsre`=1 after 960 cycles.
- Write 0x3C, then write 0x81 after `tbre` returns to 1 → two back-to-back frames with no idle gap. A third write while `tbre`=0 is ignored.
- Drive 0x5A on `rxd` → `data_ready`=1. A `rdn` pulse reads 0x5A on `data`, then `data_ready`=0.
- Send 0x11 with stop bit 0 → `data_ready` stays 0. Send 0x22 then 0x33 unread → a read returns 0x33.
- A 20-cycle low glitch on `rxd` → no byte, RX FSM back in IDLE.

Source files
------------

// File: rtl/uart_port_pkg.sv
// uart_port_pkg: shared bus width and UART FSM state encoding
package uart_port_pkg;
    localparam int UART_DATA_BUS = 8;
    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: rxd synchroniser, receive FSM and byte holding register
module uart_rx
    import uart_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rxd,
    output logic [UART_DATA_BUS-1:0] rx_byte,
    output logic                     rx_valid
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
    uart_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_cnt, bit_n;
    logic [UART_DATA_BUS-1:0] shift, shift_n, rx_byte_n;
    logic rxd_s1, rxd_s2, rxd_q, tick, mid, sample, valid_n;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {rxd_s1, rxd_s2, rxd_q} <= 3'b111;
            state    <= UART_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            {rxd_s1, rxd_s2, rxd_q} <= {rxd, rxd_s1, rxd_s2};
            state    <= state_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            rx_byte  <= rx_byte_n;
            rx_valid <= valid_n;
        end
    end
    always_comb begin
        tick    = cnt == LAST;
        mid     = cnt == MID;
        sample  = state == UART_DATA && tick;
        state_n = state;
        case (state)
            UART_IDLE:  state_n = (!rxd_s2 && rxd_q) ? UART_START : UART_IDLE;
            UART_START: state_n = mid ? (rxd_s2 ? UART_IDLE : UART_DATA) : UART_START;
            UART_DATA:  state_n = (tick && bit_cnt == 3'd7) ? UART_STOP : UART_DATA;
            UART_STOP:  state_n = tick ? UART_IDLE : UART_STOP;
        endcase
        // START counts only to mid-bit so later samples land mid-bit too
        cnt_n     = (state == UART_IDLE || (state == UART_START && mid) || tick) ? '0 : cnt + 1'b1;
        bit_n     = sample ? bit_cnt + 1'b1 : bit_cnt;
        shift_n   = sample ? {rxd_s2, shift[UART_DATA_BUS-1:1]} : shift;
        valid_n   = state == UART_STOP && tick && rxd_s2;
        rx_byte_n = valid_n ? shift : rx_byte;
    end
endmodule

// File: rtl/uart_port.sv
// uart_port: UART chip model answering the CPU rdn/wrn handshake, with serial TX and RX
module uart_port
    import uart_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    inout  wire  [UART_DATA_BUS-1:0] data,
    input  logic                     rdn,
    input  logic                     wrn,
    output logic                     data_ready,
    output logic                     tbre,
    output logic                     tsre,
    input  logic                     rxd,
    output logic                     txd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    uart_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_cnt, bit_n;
    logic [UART_DATA_BUS-1:0] shift, shift_n, tx_hold, tx_hold_n, rx_byte;
    logic wrn_s1, wrn_s2, wrn_q, rdn_s1, rdn_s2, rdn_q;
    logic hold_seen, tick, load, wr_take, tbre_n, tsre_n, rx_valid;
    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );
    assign data = rdn ? {UART_DATA_BUS{1'bz}} : rx_byte;
    assign txd  = state == UART_START ? 1'b0 : state == UART_DATA ? shift[0] : 1'b1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {wrn_s1, wrn_s2, wrn_q} <= 3'b111;
            {rdn_s1, rdn_s2, rdn_q} <= 3'b111;
            state      <= UART_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            tx_hold    <= '0;
            hold_seen  <= 1'b0;
            tbre       <= 1'b1;
            tsre       <= 1'b1;
            data_ready <= 1'b0;
        end else begin
            {wrn_s1, wrn_s2, wrn_q} <= {wrn, wrn_s1, wrn_s2};
            {rdn_s1, rdn_s2, rdn_q} <= {rdn, rdn_s1, rdn_s2};
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_n;
            shift      <= shift_n;
            tx_hold    <= tx_hold_n;
            hold_seen  <= !tbre;
            tbre       <= tbre_n;
            tsre       <= tsre_n;
            data_ready <= rx_valid ? 1'b1 : (rdn_s2 && !rdn_q) ? 1'b0 : data_ready;
        end
    end
    always_comb begin
        tick    = cnt == LAST;
        wr_take = !wrn_s2 && wrn_q && tbre;
        // hold_seen gives the holding register one settled cycle before the shifter takes it
        load    = !tbre && hold_seen && (state == UART_IDLE || (state == UART_STOP && tick));
        state_n = state;
        case (state)
            UART_IDLE:  state_n = load ? UART_START : UART_IDLE;
            UART_START: state_n = tick ? UART_DATA : UART_START;
            UART_DATA:  state_n = (tick && bit_cnt == 3'd7) ? UART_STOP : UART_DATA;
            UART_STOP:  state_n = load ? UART_START : tick ? UART_IDLE : UART_STOP;
        endcase
        cnt_n     = (state == UART_IDLE || tick) ? '0 : cnt + 1'b1;
        bit_n     = (state == UART_DATA && tick) ? bit_cnt + 1'b1 : bit_cnt;
        shift_n   = load ? tx_hold : (state == UART_DATA && tick) ? shift >> 1 : shift;
        tx_hold_n = wr_take ? data : tx_hold;
        tbre_n    = load ? 1'b1 : wr_take ? 1'b0 : tbre;
        tsre_n    = load ? 1'b0 : (state == UART_STOP && tick) ? 1'b1 : tsre;
    end
endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port: directed checks of the uart_port write/serialise and receive/read paths
module tb_uart_port;
    logic clk = 1'b0;
    logic rst, rdn, wrn, rxd, cpu_drive;
    logic [7:0] cpu_data, rd_val;
    wire  [7:0] data;
    logic data_ready, tbre, tsre, txd;
    int cyc = 0;
    int vectors = 0;
    int errors = 0;
    int c0, base, r;

    uart_port #(.CLKS_PER_BIT(96)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .rdn        (rdn),
        .wrn        (wrn),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .rxd        (rxd),
        .txd        (txd)
    );

    assign data = cpu_drive ? cpu_data : 8'bz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (data[i]);
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic cpu_write(input logic [7:0] b);
        cpu_data = b;
        cpu_drive = 1'b1;
        wrn = 1'b0;
        tick(4);
        wrn = 1'b1;
        cpu_drive = 1'b0;
        tick(4);
    endtask

    task automatic cpu_read(output logic [7:0] v);
        rdn = 1'b0;
        tick(3);
        v = data;
        rdn = 1'b1;
        tick(4);
    endtask

    // checks txd on the first and last cycle of frame bits first..9, frame start at cycle s
    task automatic check_frame(input logic [7:0] b, input int first, input int s);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int k = first; k < 10; k++) begin
            wait_to(s + 96 * k);
            chk1("tx_bit_first", txd, f[k]);
            wait_to(s + 96 * k + 95);
            chk1("tx_bit_last", txd, f[k]);
        end
        chk1("tsre_busy_last", tsre, 1'b0);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop, output int t0);
        t0 = cyc;
        rxd = 1'b0;
        for (int j = 0; j < 8; j++) begin
            wait_to(t0 + 96 * (j + 1));
            rxd = b[j];
        end
        wait_to(t0 + 864);
        rxd = stop;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        int t0;
        rx_send(b, stop, t0);
        wait_to(t0 + 960);
        rxd = 1'b1;
        tick(10);
    endtask

    initial begin
        rst = 1'b0;
        rdn = 1'b1;
        wrn = 1'b1;
        rxd = 1'b1;
        cpu_drive = 1'b0;
        cpu_data = 8'h00;
        @(posedge clk);
        #1;
        tick(3);
        chk1("rst_txd", txd, 1'b1);
        chk1("rst_tbre", tbre, 1'b1);
        chk1("rst_tsre", tsre, 1'b1);
        chk1("rst_data_ready", data_ready, 1'b0);
        chk8("rst_data_hiz", data, 8'hFF);
        rst = 1'b1;
        tick(5);

        c0 = cyc;
        cpu_data = 8'hA5;
        cpu_drive = 1'b1;
        wrn = 1'b0;
        wait_to(c0 + 2);
        chk1("a5_tbre_sync", tbre, 1'b1);
        wait_to(c0 + 3);
        chk1("a5_tbre_fall", tbre, 1'b0);
        wait_to(c0 + 4);
        chk1("a5_tbre_held", tbre, 1'b0);
        chk1("a5_txd_idle", txd, 1'b1);
        wrn = 1'b1;
        cpu_drive = 1'b0;
        wait_to(c0 + 5);
        chk1("a5_tbre_back", tbre, 1'b1);
        chk1("a5_start", txd, 1'b0);
        chk1("a5_tsre_busy", tsre, 1'b0);
        check_frame(8'hA5, 0, c0 + 5);
        wait_to(c0 + 965);
        chk1("a5_tsre_done", tsre, 1'b1);
        chk1("a5_txd_idle_end", txd, 1'b1);

        tick(5);
        c0 = cyc;
        cpu_write(8'h3C);
        chk1("b2b_tbre_after_3c", tbre, 1'b1);
        cpu_write(8'h81);
        chk1("b2b_tbre_full", tbre, 1'b0);
        cpu_write(8'hFF);
        chk1("b2b_tbre_ignored", tbre, 1'b0);
        chk1("b2b_in_start", txd, 1'b0);
        check_frame(8'h3C, 1, c0 + 5);
        wait_to(c0 + 965);
        chk1("b2b_no_gap_txd", txd, 1'b0);
        chk1("b2b_no_gap_tsre", tsre, 1'b0);
        chk1("b2b_tbre_reload", tbre, 1'b1);
        check_frame(8'h81, 0, c0 + 965);
        wait_to(c0 + 1945);
        chk1("b2b_txd_idle", txd, 1'b1);
        chk1("b2b_tsre_idle", tsre, 1'b1);
        chk1("b2b_tbre_idle", tbre, 1'b1);

        rx_send(8'h5A, 1'b1, base);
        wait_to(base + 915);
        chk1("rx5a_dr_before", data_ready, 1'b0);
        wait_to(base + 916);
        chk1("rx5a_dr_rise", data_ready, 1'b1);
        wait_to(base + 960);
        rxd = 1'b1;
        tick(10);
        rdn = 1'b0;
        tick(3);
        chk8("rx5a_read", data, 8'h5A);
        chk1("rx5a_dr_while_low", data_ready, 1'b1);
        rdn = 1'b1;
        r = cyc;
        wait_to(r + 2);
        chk1("rx5a_dr_sync", data_ready, 1'b1);
        wait_to(r + 3);
        chk1("rx5a_dr_fall", data_ready, 1'b0);
        tick(3);
        chk8("rx5a_data_hiz", data, 8'hFF);

        rx_frame(8'h11, 1'b0);
        chk1("frame_err_dr", data_ready, 1'b0);
        rx_frame(8'h22, 1'b1);
        chk1("ovr_dr_first", data_ready, 1'b1);
        rx_frame(8'h33, 1'b1);
        chk1("ovr_dr_second", data_ready, 1'b1);
        cpu_read(rd_val);
        chk8("ovr_read", rd_val, 8'h33);
        chk1("ovr_dr_cleared", data_ready, 1'b0);

        rxd = 1'b0;
        tick(20);
        rxd = 1'b1;
        tick(960);
        chk1("glitch_dr", data_ready, 1'b0);
        rx_frame(8'hC3, 1'b1);
        chk1("post_glitch_dr", data_ready, 1'b1);

        c0 = cyc;
        cpu_write(8'h00);
        wait_to(c0 + 300);
        chk1("mid_tx_txd", txd, 1'b0);
        chk1("mid_tx_tsre", tsre, 1'b0);
        rst = 1'b0;
        tick(1);
        chk1("abort_txd", txd, 1'b1);
        chk1("abort_tbre", tbre, 1'b1);
        chk1("abort_tsre", tsre, 1'b1);
        chk1("abort_dr", data_ready, 1'b0);
        chk8("abort_data_hiz", data, 8'hFF);
        rst = 1'b1;
        tick(2);
        rdn = 1'b0;
        tick(1);
        chk8("abort_hold_cleared", data, 8'h00);
        rdn = 1'b1;
        tick(1000);
        chk1("abort_no_resume_txd", txd, 1'b1);
        chk1("abort_no_resume_tsre", tsre, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
